// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI mode-0 register-access frame controller.
// Sends a command byte {rd_wr, addr}, then either one write byte or N read
// bytes, using an external clock divider that produces s_clk in the clk domain.
// Optional macro SPI_CS_GUARD_EN stretches CS setup/hold to GUARD_CYCLES and
// adds an idle guard after cs_n rises. Default build: 1-clk setup/hold.
module spi_xfer_ctrl #(
  parameter int unsigned MAX_BYTES    = 15,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rd_wr,
  input  logic [6:0] addr,
  input  logic [3:0] nbytes,
  input  logic [7:0] wr_data,
  output logic       enable_div,
  input  logic       s_clk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

`ifdef SPI_CS_GUARD_EN
  localparam int unsigned GUARD_LEN = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
`else
  localparam int unsigned GUARD_LEN = 1;
`endif
  // Timer is wide enough for the guard length even when the guard is off.
  localparam int unsigned TW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_LEN - 1);
  localparam int unsigned MAX_LIM = (MAX_BYTES < 1) ? 1 : ((MAX_BYTES > 15) ? 15 : MAX_BYTES);
  localparam logic [3:0] MAX_CNT = 4'(MAX_LIM);

  // Read byte count: 0 means one byte, large requests saturate at MAX_CNT.
  function automatic logic [3:0] clamp_count(input logic [3:0] n);
    logic [3:0] r;
    if (n == 4'd0) begin
      r = 4'd1;
    end else if (n > MAX_CNT) begin
      r = MAX_CNT;
    end else begin
      r = n;
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    n_data_q, n_data_d;
  logic          rd_q, rd_d;
  logic [7:0]    wr_byte_q, wr_byte_d;
  logic [6:0]    tx_q, tx_d;        // bits still to send after the one on mosi
  logic [6:0]    rx_shift_q, rx_shift_d;
  logic          s_clk_d_q;
  logic          cs_n_q, cs_n_d;
  logic          en_q, en_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rise_s, fall_s, accept_s;
  logic [7:0]    next_byte_s;

  // Frame sequencing, bit shifting and receive assembly.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    n_data_d    = n_data_q;
    rd_d        = rd_q;
    wr_byte_d   = wr_byte_q;
    tx_d        = tx_q;
    rx_shift_d  = rx_shift_q;
    cs_n_d      = cs_n_q;
    en_d        = en_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    accept_s    = 1'b0;
    rise_s      = s_clk & ~s_clk_d_q;
    fall_s      = ~s_clk & s_clk_d_q;
    next_byte_s = rd_q ? 8'h00 : wr_byte_q;

    case (state_q)
      ST_IDLE: begin
`ifdef SPI_CS_GUARD_EN
        if (timer_q != {TW{1'b0}}) begin
          timer_d = timer_q - TW'(1'b1);
        end else if (start) begin
          accept_s = 1'b1;
        end else begin
          timer_d = timer_q;
        end
`else
        if (start) begin
          accept_s = 1'b1;
        end else begin
          timer_d = timer_q;
        end
`endif
      end
      ST_SETUP: begin
        if (timer_q == GUARD_LAST) begin
          state_d = ST_XFER;
          timer_d = {TW{1'b0}};
          en_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      ST_XFER: begin
        if (rise_s) begin
          rx_shift_d = {rx_shift_q[5:0], miso};
          if (rd_q && (byte_cnt_q != 4'd0) && (bit_cnt_q == 3'd7)) begin
            rx_data_d  = {rx_shift_q, miso};
            rx_valid_d = 1'b1;
          end else begin
            rx_valid_d = 1'b0;
          end
        end else if (fall_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end else if (byte_cnt_q == n_data_q) begin
            en_d    = 1'b0;
            state_d = ST_HOLD;
            timer_d = {TW{1'b0}};
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            mosi_d     = next_byte_s[7];
            tx_d       = next_byte_s[6:0];
          end
        end else begin
          rx_shift_d = rx_shift_q;
        end
      end
      ST_HOLD: begin
        if (timer_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
`ifdef SPI_CS_GUARD_EN
          timer_d = TW'(GUARD_LEN);
`else
          timer_d = {TW{1'b0}};
`endif
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
        timer_d = {TW{1'b0}};
      end
    endcase

    if (accept_s) begin
      state_d    = ST_SETUP;
      timer_d    = {TW{1'b0}};
      cs_n_d     = 1'b0;
      busy_d     = 1'b1;
      rd_d       = rd_wr;
      wr_byte_d  = wr_data;
      n_data_d   = rd_wr ? clamp_count(nbytes) : 4'd1;
      mosi_d     = rd_wr;
      tx_d       = addr;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      rx_shift_d = 7'd0;
    end else begin
      accept_s = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= {TW{1'b0}};
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      n_data_q   <= 4'd0;
      rd_q       <= 1'b0;
      wr_byte_q  <= 8'h00;
      tx_q       <= 7'd0;
      rx_shift_q <= 7'd0;
      s_clk_d_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      en_q       <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      n_data_q   <= n_data_d;
      rd_q       <= rd_d;
      wr_byte_q  <= wr_byte_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      s_clk_d_q  <= s_clk;
      cs_n_q     <= cs_n_d;
      en_q       <= en_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign enable_div = en_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: divide-by-10 clock model, SPI slave model and a
// scoreboard of expected mosi bytes and expected rx bytes.
module tb_spi_xfer_ctrl;

`ifdef SPI_CS_GUARD_EN
  localparam int GL = 4;
`else
  localparam int GL = 1;
`endif
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rd_wr = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [3:0] nbytes = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       enable_div, s_clk, cs_n, mosi, miso, busy, done, rx_valid;
  logic [7:0] rx_data;
  logic [7:0] sreg = 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int rx_cnt = 0;
  int done_cnt = 0;
  int dcnt = 0;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] slave_q[$];
  logic [7:0] next_miso[$];

  spi_xfer_ctrl #(.MAX_BYTES(MAXB), .GUARD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_wr(rd_wr), .addr(addr),
    .nbytes(nbytes), .wr_data(wr_data), .enable_div(enable_div), .s_clk(s_clk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso), .busy(busy), .done(done),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;
  assign miso = sreg[7];

  // Divider model: s_clk period 10 clk, held low while enable_div is low.
  always @(posedge clk) begin
    if (!enable_div) begin
      dcnt  <= 0;
      s_clk <= 1'b0;
    end else begin
      dcnt  <= (dcnt == 9) ? 0 : dcnt + 1;
      s_clk <= (dcnt >= 4 && dcnt <= 8);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor + slave: sampled on the falling clk edge.
  initial begin
    logic       prev_s, prev_cs;
    logic [7:0] mbits;
    int         mcnt, sbit;
    prev_s = 1'b0; prev_cs = 1'b1; mbits = 8'h00; mcnt = 0; sbit = 0;
    forever begin
      @(negedge clk);
      if (prev_cs && !cs_n) begin
        sreg = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
        sbit = 0;
        mcnt = 0;
      end
      if (!cs_n && s_clk && !prev_s) begin
        rise_cnt++;
        mbits = {mbits[6:0], mosi};
        mcnt++;
        if (mcnt == 8) begin
          mcnt = 0;
          if (exp_mosi.size() == 0) check_eq("mosi_extra", 32'd1, 32'd0);
          else check_eq("mosi_byte", 32'(mbits), 32'(exp_mosi.pop_front()));
        end
      end
      if (!cs_n && !s_clk && prev_s) begin
        sbit++;
        if (sbit == 8) begin
          sbit = 0;
          sreg = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
        end else begin
          sreg = sreg << 1;
        end
      end
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) check_eq("rx_extra", 32'd1, 32'd0);
        else check_eq("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (done) done_cnt++;
      prev_s  = s_clk;
      prev_cs = cs_n;
    end
  end

  // Queue up expectations and slave bytes for one frame; returns data byte count.
  task automatic plan_frame(input logic rd, input logic [6:0] a, input logic [3:0] nb,
                            input logic [7:0] wd, output int n);
    logic [7:0] b;
    n = !rd ? 1 : (nb == 4'd0) ? 1 : (int'(nb) > MAXB) ? MAXB : int'(nb);
    exp_mosi.push_back({rd, a});
    slave_q.push_back(8'h00);
    for (int i = 0; i < n; i++) begin
      exp_mosi.push_back(rd ? 8'h00 : wd);
      b = (next_miso.size() > 0) ? next_miso.pop_front() : 8'($urandom);
      slave_q.push_back(b);
      if (rd) exp_rx.push_back(b);
    end
  endtask

  task automatic scramble();
    rd_wr = 1'($urandom); addr = 7'($urandom); nbytes = 4'($urandom); wr_data = 8'($urandom);
  endtask

  task automatic run_frame(input logic rd, input logic [6:0] a, input logic [3:0] nb,
                           input logic [7:0] wd, input bit flood);
    int n, cyc, en_cyc, fall_cyc, end_cyc, r0, x0, d0;
    bit prev_en, got_done;
    plan_frame(rd, a, nb, wd, n);
    r0 = rise_cnt; x0 = rx_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    check_eq("idle_ready", {30'd0, cs_n, busy}, 32'd2);
    start = 1'b1; rd_wr = rd; addr = a; nbytes = nb; wr_data = wd;
    @(posedge clk); #1;
    check_eq("accept", {30'd0, cs_n, busy}, 32'd1);
    if (!flood) start = 1'b0;
    scramble();
    cyc = 0; en_cyc = -1; fall_cyc = -1; end_cyc = -1; prev_en = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      if (flood) begin start = 1'b1; scramble(); end
      @(posedge clk); #1;
      cyc++;
      if (en_cyc < 0 && enable_div) en_cyc = cyc;
      if (prev_en && !enable_div) fall_cyc = cyc;
      prev_en = enable_div;
      if (done) begin got_done = 1'b1; end_cyc = cyc; end
    end
    start = 1'b0;
    check_eq("done_seen", 32'(got_done), 32'd1);
    check_eq("setup_len", en_cyc, GL);
    check_eq("hold_len", end_cyc - fall_cyc, GL);
    check_eq("end_state", {29'd0, cs_n, busy, mosi}, 32'd4);
    @(negedge clk);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("rise_count", rise_cnt - r0, 8 * (1 + n));
    check_eq("rx_count", rx_cnt - x0, rd ? n : 0);
    check_eq("queues_empty", exp_mosi.size() + exp_rx.size(), 0);
  endtask

  initial begin
    int n, cyc, r0, d0;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_en", 32'(enable_div), 32'd0);
    check_eq("rst_mosi_busy", {30'd0, mosi, busy}, 32'd0);
    check_eq("rst_pulses", {30'd0, done, rx_valid}, 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Read of three bytes with fixed slave data.
    next_miso.push_back(8'h80); next_miso.push_back(8'h00); next_miso.push_back(8'h12);
    run_frame(1'b1, 7'h7A, 4'd3, 8'h00, 1'b0);
    // Write: nbytes is ignored.
    run_frame(1'b0, 7'h74, 4'd5, 8'h27, 1'b0);
    // nbytes 0 -> one byte, nbytes 15 -> MAX_BYTES.
    run_frame(1'b1, 7'h15, 4'd0, 8'h00, 1'b0);
    run_frame(1'b1, 7'h55, 4'd15, 8'h00, 1'b0);
    // start held every cycle of a frame -> one frame only.
    run_frame(1'b1, 7'h11, 4'd2, 8'h00, 1'b1);
`ifdef SPI_CS_GUARD_EN
    // Starts inside the idle guard are ignored.
    for (int k = 1; k < GL; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("guard_ignore", {30'd0, cs_n, busy}, 32'd2);
    start = 1'b0;
    @(negedge clk);
`endif
    // Next frame right after done (back-to-back without guard).
    run_frame(1'b0, 7'h22, 4'd0, 8'hA5, 1'b0);

    // Reset after 12 rises aborts with no done.
    plan_frame(1'b1, 7'h3C, 4'd3, 8'h00, n);
    r0 = rise_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; rd_wr = 1'b1; addr = 7'h3C; nbytes = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (rise_cnt - r0 < 12 && cyc < 2000) begin @(negedge clk); cyc++; end
    check_eq("abort_rises_reached", 32'(rise_cnt - r0 >= 12), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_cs_en", {30'd0, cs_n, enable_div}, 32'd2);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rx_data", 32'(rx_data), 32'd0);
    exp_mosi.delete(); exp_rx.delete(); slave_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("abort_no_done", done_cnt - d0, 0);
    next_miso.push_back(8'hC3); next_miso.push_back(8'h5A);
    run_frame(1'b1, 7'h3C, 4'd2, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
